// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor.
// The master issues operands and the slave returns the result and GB80 flags.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
) ();
    logic             i_start;
    logic [WIDTH-1:0] i_data_A;
    logic [WIDTH-1:0] i_data_B;
    logic             i_borrow;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow;
    logic             o_half_borrow;
    logic             o_zero;

    modport master (
        output i_start, i_data_A, i_data_B, i_borrow,
        input  o_busy, o_done, o_diff, o_borrow, o_half_borrow, o_zero
    );

    modport slave (
        input  i_start, i_data_A, i_data_B, i_borrow,
        output o_busy, o_done, o_diff, o_borrow, o_half_borrow, o_zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - borrow_in, LSB first, one bit per clock.
// Produces the GB80 zero, half-borrow and borrow flags on completion.
module serial_subtractor #(
    parameter int WIDTH    = 8,
    parameter int HALF_BIT = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    serial_subtractor_if.slave   bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             br_q;
    logic             half_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             half_out_q;
    logic             zero_q;

    logic             d_bit;
    logic             br_d;
    logic [WIDTH-1:0] res_d;

    // One full-subtractor cell applied to the current LSBs of the work registers.
    always_comb begin
        d_bit = a_q[0] ^ b_q[0] ^ br_q;
        br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_d = {d_bit, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            br_q       <= 1'b0;
            half_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            half_out_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_d;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                        half_q <= br_d;
                    end
                    // Last bit: publish the result and flags together.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        diff_q     <= res_d;
                        borrow_q   <= br_d;
                        half_out_q <= (HALF_BIT == WIDTH) ? br_d : half_q;
                        zero_q     <= (res_d == '0);
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    if (bus.i_start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        a_q     <= bus.i_data_A;
                        b_q     <= bus.i_data_B;
                        br_q    <= bus.i_borrow;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;
    assign bus.o_diff        = diff_q;
    assign bus.o_borrow      = borrow_q;
    assign bus.o_half_borrow = half_out_q;
    assign bus.o_zero        = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed GB80 cases plus a random sweep
// against an arithmetic reference (A - B - bin with unsigned compares for flags).
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [W-1:0] prev_diff;
    logic         prev_c;
    logic         prev_h;
    logic         prev_z;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W), .HALF_BIT(4)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered in the cycle that drives i_start; returns in the o_done cycle.
    // ign_cyc in 1..W raises a stray i_start with 0xFF-0xFF during RUN.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin, input int ign_cyc);
        int           ai, bi, bn, busy_n, done_at;
        logic [W-1:0] ed;
        logic         ec, eh, ez;
        bus.i_data_A = a;
        bus.i_data_B = b;
        bus.i_borrow = bin;
        bus.i_start  = 1'b1;
        tick();
        bus.i_start  = 1'b0;
        bus.i_data_A = W'($urandom);
        bus.i_data_B = W'($urandom);
        bus.i_borrow = 1'($urandom);
        busy_n  = 0;
        done_at = 0;
        for (int c = 1; c <= W + 1; c++) begin
            if (c == 1) begin
                chk("hold_diff", 32'(bus.o_diff), 32'(prev_diff));
                chk("hold_flags", {29'd0, bus.o_borrow, bus.o_half_borrow, bus.o_zero},
                    {29'd0, prev_c, prev_h, prev_z});
            end
            if (bus.o_busy) busy_n++;
            if (bus.o_done && done_at == 0) done_at = c;
            if (c <= W) begin
                if (c == ign_cyc) begin
                    bus.i_start  = 1'b1;
                    bus.i_data_A = '1;
                    bus.i_data_B = '1;
                end
                tick();
                bus.i_start = 1'b0;
            end
        end
        ai = int'(a);
        bi = int'(b);
        bn = int'(bin);
        ed = W'(ai - bi - bn);
        ec = (ai < bi + bn);
        eh = ((ai & 15) < (bi & 15) + bn);
        ez = (ed == '0);
        chk("done_cycle", 32'(done_at), 32'(W + 1));
        chk("busy_cycles", 32'(busy_n), 32'(W));
        chk("busy_in_done", 32'(bus.o_busy), 32'd0);
        chk("diff", 32'(bus.o_diff), 32'(ed));
        chk("borrow", 32'(bus.o_borrow), 32'(ec));
        chk("half_borrow", 32'(bus.o_half_borrow), 32'(eh));
        chk("zero", 32'(bus.o_zero), 32'(ez));
        prev_diff = ed;
        prev_c    = ec;
        prev_h    = eh;
        prev_z    = ez;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {26'd0, bus.o_busy, bus.o_done, bus.o_borrow, bus.o_half_borrow,
                  bus.o_zero, |bus.o_diff}, 32'd0);
    endtask

    initial begin
        int done_seen;
        n_checks     = 0;
        n_errors     = 0;
        prev_diff    = '0;
        prev_c       = 1'b0;
        prev_h       = 1'b0;
        prev_z       = 1'b0;
        bus.i_start  = 1'b0;
        bus.i_data_A = '0;
        bus.i_data_B = '0;
        bus.i_borrow = 1'b0;
        rst          = 1'b1;
        tick();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        chk_all_zero("reset_outputs");
        rst = 1'b0;
        tick();
        chk_all_zero("idle_outputs");

        do_op(8'h3C, 8'h2F, 1'b0, 0);
        tick();
        do_op(8'h00, 8'h01, 1'b0, 0);
        tick();
        do_op(8'h42, 8'h42, 1'b0, 0);
        tick();
        do_op(8'h10, 8'h0F, 1'b1, 0);
        tick();
        do_op(8'h05, 8'h05, 1'b1, 0);
        tick();

        // Stray start in RUN is ignored, then a back-to-back accept in the DONE cycle.
        do_op(8'h80, 8'h01, 1'b0, 3);
        do_op(8'h05, 8'h05, 1'b1, 0);
        tick();

        // Abort mid-RUN.
        done_seen    = 0;
        bus.i_data_A = 8'h37;
        bus.i_data_B = 8'h12;
        bus.i_borrow = 1'b0;
        bus.i_start  = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (bus.o_done) done_seen++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (bus.o_done) done_seen++;
        chk_all_zero("abort_outputs");
        tick();
        if (bus.o_done) done_seen++;
        chk("abort_no_done", 32'(done_seen), 32'd0);
        chk_all_zero("abort_idle");
        prev_diff = '0;
        prev_c    = 1'b0;
        prev_h    = 1'b0;
        prev_z    = 1'b0;
        do_op(8'h22, 8'h11, 1'b0, 0);

        for (int i = 0; i < 1500; i++) begin
            logic [W-1:0] ra, rb;
            logic         rbin;
            int           ign;
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            ign  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
            if ($urandom_range(0, 1) == 1) tick();
            do_op(ra, rb, rbin, ign);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
